iter_alu_miter: RTL
===================

// Module: iter_alu_miter
// PURPOSE
//   Multi-cycle, parametrised successor of the combinational ALU/golden miter used for SMT sweeping.
//   Computes add/sub/mul/div on WIDTH-bit operands using a valid/ready handshake.
//   Multiply and divide are iterative (shift-add, restoring), not single-cycle operators.
//   Used as a sequential sweeping target: equivalence under control==4'b1000 must hold across cycles.
// PARAMETERS
//   WIDTH     64   operand width in bits; legal range 4..128; result width is 2*WIDTH
//   CNT_W     $clog2(WIDTH+1)   iteration counter width (derived; do not override)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        operand/control beat valid
//   in_ready   out  1        block can accept a beat
//   a          in   WIDTH    operand A
//   b          in   WIDTH    operand B
//   control    in   4        [1:0] A-preprocess select, [3:2] op select
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out        out  2*WIDTH  result
//   result     out  1        miter mismatch flag (GOLDEN_CHECK_EN only; else tied 0)
//   condition  out  1        1 when the captured control==4'b1000 (valid with out_valid)
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=1 once rst deasserts; out_valid=0; out=0; result=0; condition=0.
//   - Preprocess (applied at capture): ctl[1:0] 00:A  01:{1'b0,A[W-2:0]}  10:{A[W-1:1],1'b0}  11:A&B.
//   - Ops ctl[3:2]: 00 add, 01 sub, 10 mul, 11 udiv. All arithmetic is done at 2*WIDTH.
//       add: zero-extended sum, carry lands in bit WIDTH.
//       sub: 2*WIDTH two's-complement of zext(A')-zext(B); upper bits are ones on borrow.
//       mul: full unsigned product.
//       div: unsigned quotient, zero-extended. B==0 -> quotient all-ones (WIDTH bits), zero-extended.
//   - FSM IDLE->BUSY->DONE->IDLE.
//       IDLE: in_ready=1. On in_valid, capture a, b, control and go to BUSY.
//       BUSY: add/sub finish in 1 cycle; mul/div run exactly WIDTH iterations (counter 0..WIDTH-1).
//       DONE: out_valid=1; out, result and condition held stable until out_ready.
//             On out_valid&&out_ready go to IDLE.
//   - Latency, capture edge to out_valid: add/sub 2 cycles; mul/div WIDTH+1 cycles.
//   - in_ready=0 in BUSY and DONE: no pipelining, one transaction in flight.
//   - Input changes while BUSY are ignored; outputs never glitch while out_valid=1.
//   - Async reset mid-operation: abort, discard the transaction, return to reset values.
// CONFIGURATION
//   Macro ITER_ALU_GOLDEN_CHECK_EN:
//   - Defined: an embedded golden model computes zext(a)*zext(b) from captured raw operands
//     (combinational, registered at capture). In DONE, result = |(out ^ golden).
//     Stays 0 whenever condition=1 in a correct design.
//   - Undefined: golden logic is absent; result is tied 0; condition is still produced.
// STRUCTURE
//   Package iter_alu_pkg:
//     typedef enum logic[1:0] {OP_ADD,OP_SUB,OP_MUL,OP_DIV};
//     typedef enum logic[1:0] {PRE_PASS,PRE_CLRMSB,PRE_CLRLSB,PRE_AND};
//     typedef enum logic[1:0] {S_IDLE,S_BUSY,S_DONE};
//     localparam logic[3:0] MITER_CTRL = 4'b1000;
//   Sub-module iter_muldiv_core: shared shift-add multiplier and restoring divider.
//     Interface: start, is_div, a, b -> done, res[2*WIDTH-1:0]; WIDTH iterations.
//   Top holds FSM, preprocess, add/sub path, handshake and optional golden check.
// TESTING
//   1 WIDTH=8, ctl=1000, a=13, b=11, out_ready=1 -> out=143 after 9 cycles; condition=1; result=0.
//   2 ctl=0100, a=3, b=5 -> out=2^(2W)-2 (all ones except LSB); latency 2 cycles; condition=0.
//   3 ctl=1100, a=200, b=0 (W=8) -> out=16'h00FF; ctl=1100, a=200, b=7 -> out=28.
//   4 ctl=0011 add with a=8'hF0, b=8'h3C -> A'=8'h30, out=16'h006C; ctl=0001, a=8'hFF, b=1 -> out=16'h0080.
//   5 Hold out_ready=0 for 5 cycles after DONE -> out_valid, out stable; in_ready=0; in_valid pulses ignored.
//   6 Assert rst at iteration 3 of mul -> next cycle out_valid=0, in_ready=1; a new beat completes correctly.
//   Run all of the above with and without ITER_ALU_GOLDEN_CHECK_EN, at WIDTH=8 and WIDTH=64.
//   Add a random ctl=1000 regression that checks result==0 throughout.

Source files
------------

// File: rtl/iter_alu_pkg.sv
// Shared types and constants for the iterative ALU miter.
package iter_alu_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {PRE_PASS, PRE_CLRMSB, PRE_CLRLSB, PRE_AND} pre_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  // Control beat layout: [3:2] op select, [1:0] A-preprocess select.
  typedef struct packed {
    op_e  op;
    pre_e pre;
  } ctl_t;

  localparam logic [3:0] MITER_CTRL = 4'b1000;

  // Multiply and divide go through the iterative core; add/sub do not.
  function automatic logic is_iterative(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// Shared iterative engine: shift-add unsigned multiplier and restoring
// unsigned divider, both taking exactly WIDTH iterations after start.
// res holds the final value from the cycle done pulses until the next start.
module iter_muldiv_core
  import iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RW    = 2 * WIDTH;

  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [RW-1:0]    acc_q,    acc_d;    // mul: partial product; div: {rem, quot}
  logic [RW-1:0]    mcand_q,  mcand_d;  // mul: multiplicand shifted left each step
  logic [WIDTH-1:0] opb_q,    opb_d;    // mul: multiplier shifted right; div: divisor

  logic [WIDTH:0]   div_hi;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [RW-1:0]    div_next;
  logic             last_c;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_hi   = acc_q[RW-1:WIDTH-1];
    div_ok   = (div_hi >= {1'b0, opb_q});
    div_rem  = WIDTH'(div_hi - {1'b0, opb_q});
    div_next = div_ok ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[RW-2:0], 1'b0};
    last_c   = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Iteration control and datapath update.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;

    if (start && !busy_q) begin
      busy_d   = 1'b1;
      is_div_d = is_div;
      cnt_d    = '0;
      opb_d    = b;
      if (is_div) begin
        acc_d   = {WIDTH'(0), a};
        mcand_d = '0;
      end else begin
        acc_d   = '0;
        mcand_d = {WIDTH'(0), a};
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_div_q) begin
        // Drop the remainder on the last step so res is the zero-extended quotient.
        acc_d = last_c ? {WIDTH'(0), div_next[WIDTH-1:0]} : div_next;
      end else begin
        acc_d   = opb_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d = mcand_q << 1;
        opb_d   = opb_q >> 1;
      end
      if (last_c) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
    end
  end

  assign done = done_q;
  assign res  = acc_q;

endmodule

// File: rtl/iter_alu_miter.sv
// Multi-cycle ALU miter target for sequential SMT sweeping.
// add/sub/mul/div on WIDTH-bit operands with a valid/ready handshake and
// one transaction in flight. Optional golden multiply check is enabled by
// defining ITER_ALU_GOLDEN_CHECK_EN; otherwise result is tied low.
module iter_alu_miter
  import iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               result,
  output logic               condition
);

  localparam int unsigned RW = 2 * WIDTH;

  state_e           state_q,     state_d;
  ctl_t             ctl_q,       ctl_d;
  logic [WIDTH-1:0] opa_q,       opa_d;
  logic [WIDTH-1:0] opb_q,       opb_d;
  logic [RW-1:0]    out_q,       out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;
  logic             condition_q, condition_d;
  logic             result_q,    result_d;
  logic             as_done_q,   as_done_d;
`ifdef ITER_ALU_GOLDEN_CHECK_EN
  logic [RW-1:0]    golden_q,    golden_d;
`endif

  ctl_t             in_ctl_c;
  logic [WIDTH-1:0] pre_a_c;
  logic [RW-1:0]    addsub_c;
  logic [RW-1:0]    final_c;
  logic             core_start_c;
  logic             core_done;
  logic [RW-1:0]    core_res;

  assign in_ctl_c = ctl_t'(control);

  // Operand A preprocessing, applied to the incoming beat at capture.
  always_comb begin
    pre_a_c = a;
    case (in_ctl_c.pre)
      PRE_PASS:   pre_a_c = a;
      PRE_CLRMSB: pre_a_c = {1'b0, a[WIDTH-2:0]};
      PRE_CLRLSB: pre_a_c = {a[WIDTH-1:1], 1'b0};
      PRE_AND:    pre_a_c = a & b;
      default:    pre_a_c = a;
    endcase
  end

  // Single-cycle add/sub on captured operands, and final result select.
  always_comb begin
    if (ctl_q.op == OP_SUB) begin
      addsub_c = RW'(opa_q) - RW'(opb_q);
    end else begin
      addsub_c = RW'(opa_q) + RW'(opb_q);
    end
    final_c = is_iterative(ctl_q.op) ? core_res : addsub_c;
  end

  iter_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (core_start_c),
    .is_div (in_ctl_c.op == OP_DIV),
    .a      (pre_a_c),
    .b      (b),
    .done   (core_done),
    .res    (core_res)
  );

  // Transaction FSM: capture in IDLE, compute in BUSY, hold result in DONE.
  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    condition_d  = condition_q;
    result_d     = result_q;
    as_done_d    = 1'b0;
    core_start_c = 1'b0;
`ifdef ITER_ALU_GOLDEN_CHECK_EN
    golden_d     = golden_q;
`endif

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          core_start_c = is_iterative(in_ctl_c.op);
          state_d      = S_BUSY;
          ctl_d        = in_ctl_c;
          opa_d        = pre_a_c;
          opb_d        = b;
          in_ready_d   = 1'b0;
`ifdef ITER_ALU_GOLDEN_CHECK_EN
          golden_d     = RW'(a) * RW'(b);
`endif
        end
      end

      S_BUSY: begin
        if (is_iterative(ctl_q.op) ? core_done : as_done_q) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_d       = final_c;
          condition_d = (ctl_q == MITER_CTRL);
`ifdef ITER_ALU_GOLDEN_CHECK_EN
          result_d    = |(final_c ^ golden_q);
`else
          result_d    = 1'b0;
`endif
        end else begin
          // Add/sub spend one extra BUSY cycle so latency is two cycles.
          as_done_d = !is_iterative(ctl_q.op);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctl_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      condition_q <= 1'b0;
      result_q    <= 1'b0;
      as_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      condition_q <= condition_d;
      result_q    <= result_d;
      as_done_q   <= as_done_d;
    end
  end

`ifdef ITER_ALU_GOLDEN_CHECK_EN
  // Golden product of the raw captured operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      golden_q <= '0;
    end else begin
      golden_q <= golden_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign result    = result_q;
  assign condition = condition_q;

endmodule
